serdes_lane: RTL and testbench

SERDES_LANE -- requirements
Module: serdes_lane

---
 rtl/serdes_lane.sv | 145 ++++++++++++++
 tb/tb_serdes_lane.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_lane.sv
// serdes_lane: one serial lane with an LSB-first serialiser and a comma-aligned
// deserialiser. TX and RX share only the clock and reset; they keep no common state.
//
// RX state | meaning
// ---------+-------------------------------------------------------------
// HUNT     | no word boundary yet; waiting for COMMA in the bit window
// LOCKED   | boundary known; a word is emitted every WIDTH bits
module serdes_lane #(
  parameter int unsigned      WIDTH     = 10,
  parameter logic [WIDTH-1:0] COMMA     = 10'b0011111010,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'b0011111010,
  parameter bit               ALIGN_EN  = 1'b1
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] TX_D,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic             TX_S,
  input  logic             RX_S,
  input  logic             RX_REALIGN,
  output logic [WIDTH-1:0] RX_D,
  output logic             RX_VALID,
  output logic             RX_LOCKED,
  output logic             RX_SLIP
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rx_state_t;

  // Without alignment the receiver never hunts: the boundary is fixed by reset.
  localparam rx_state_t RST_STATE = ALIGN_EN ? HUNT : LOCKED;

  // ---------------------------------------------------------------- TX
  logic [WIDTH-1:0] tx_sr, tx_sr_n;
  logic [CW-1:0]    tc, tc_n;

  assign TX_READY = (tc == LAST);
  assign TX_S     = tx_sr[0];

  // Next TX word/bit: reload every WIDTH edges (idle word if nothing offered), else shift.
  always_comb begin
    tx_sr_n = {1'b0, tx_sr[WIDTH-1:1]};
    tc_n    = tc + CW'(1);
    if (tc == LAST) begin
      tx_sr_n = TX_VALID ? TX_D : IDLE_WORD;
      tc_n    = '0;
    end
  end

  // TX shift register and bit counter.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_sr <= '0;
      tc    <= LAST;
    end else begin
      tx_sr <= tx_sr_n;
      tc    <= tc_n;
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t        state, state_n;
  logic [WIDTH-1:0] win, nw;
  logic [CW-1:0]    rc, rc_n;
  logic [WIDTH-1:0] rx_d_q, rx_d_n;
  logic             rx_valid_q, rx_valid_n;
  logic             rx_slip_q, rx_slip_n;
  logic             comma_hit;

  // The newest bit enters at the MSB so the oldest bit lands in bit 0 (LSB-first line order).
  assign nw        = {RX_S, win[WIDTH-1:1]};
  assign comma_hit = (nw == COMMA);

  // Receiver next-state and output decode; a forced realign overrides everything else.
  always_comb begin
    state_n    = state;
    rc_n       = rc;
    rx_d_n     = rx_d_q;
    rx_valid_n = 1'b0;
    rx_slip_n  = 1'b0;
    if (ALIGN_EN && RX_REALIGN) begin
      state_n = HUNT;
    end else begin
      case (state)
        HUNT: begin
          if (comma_hit) begin
            state_n    = LOCKED;
            rc_n       = '0;
            rx_d_n     = nw;
            rx_valid_n = 1'b1;
          end
        end
        LOCKED: begin
          if (rc == LAST) begin
            rc_n       = '0;
            rx_d_n     = nw;
            rx_valid_n = 1'b1;
          end else if (ALIGN_EN && comma_hit) begin
            // Comma seen off the current boundary: adopt its boundary.
            rc_n       = '0;
            rx_d_n     = nw;
            rx_valid_n = 1'b1;
            rx_slip_n  = 1'b1;
          end else begin
            rc_n = rc + CW'(1);
          end
        end
      endcase
    end
    if (!ALIGN_EN) begin
      state_n = LOCKED;
    end
  end

  // Receiver registers: window, state, bit counter and the word/pulse outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      win        <= '0;
      state      <= RST_STATE;
      rc         <= '0;
      rx_d_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_slip_q  <= 1'b0;
    end else begin
      win        <= nw;
      state      <= state_n;
      rc         <= rc_n;
      rx_d_q     <= rx_d_n;
      rx_valid_q <= rx_valid_n;
      rx_slip_q  <= rx_slip_n;
    end
  end

  assign RX_D      = rx_d_q;
  assign RX_VALID  = rx_valid_q;
  assign RX_SLIP   = rx_slip_q;
  assign RX_LOCKED = (state == LOCKED);

endmodule

// File: tb/tb_serdes_lane.sv
// Directed bench for serdes_lane (WIDTH=10): a loopback instance with alignment
// and a second instance with alignment disabled.
module tb_serdes_lane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // aligned instance
  logic       rst_n, tx_valid, tx_ready, tx_s, rx_s, rx_realign;
  logic       rx_valid, rx_locked, rx_slip;
  logic [9:0] tx_d, rx_d;
  logic       lb, rx_drv;
  assign rx_s = lb ? tx_s : rx_drv;

  // free-running instance
  logic       rst1_n, tx1_valid, tx1_ready, tx1_s, rx1_s, realign1;
  logic       rx1_valid, rx1_locked, rx1_slip;
  logic [9:0] tx1_d, rx1_d;

  serdes_lane u_dut (
    .CLOCK(clk), .RESET_N(rst_n), .TX_D(tx_d), .TX_VALID(tx_valid),
    .TX_READY(tx_ready), .TX_S(tx_s), .RX_S(rx_s), .RX_REALIGN(rx_realign),
    .RX_D(rx_d), .RX_VALID(rx_valid), .RX_LOCKED(rx_locked), .RX_SLIP(rx_slip)
  );

  serdes_lane #(.ALIGN_EN(1'b0)) u_dut_free (
    .CLOCK(clk), .RESET_N(rst1_n), .TX_D(tx1_d), .TX_VALID(tx1_valid),
    .TX_READY(tx1_ready), .TX_S(tx1_s), .RX_S(rx1_s), .RX_REALIGN(realign1),
    .RX_D(rx1_d), .RX_VALID(rx1_valid), .RX_LOCKED(rx1_locked), .RX_SLIP(rx1_slip)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int slips = 0;
  int vcnt  = 0;
  int lcnt  = 0;

  logic [9:0] idle_w = 10'h0FA;

  typedef struct {
    int         e;
    logic       ts;
    logic       rdy;
    logic       v;
    logic       lk;
    logic [9:0] d;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int tgt);
    while (cyc < tgt) begin
      tick();
      if (rx_slip) slips++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc1, acc2, j;

    // Loopback idle stream after reset: TX_S carries bit (e-1)%10 of 0x0FA after
    // edge e; RX samples TX_S one edge later, so the first full comma is at edge 11.
    vt[0]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[1]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[2]  = '{3,  1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[3]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[4]  = '{5,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[5]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[6]  = '{7,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[7]  = '{8,  1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[8]  = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[9]  = '{10, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
    vt[10] = '{11, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0FA};
    vt[11] = '{12, 1'b1, 1'b0, 1'b0, 1'b1, 10'h0FA};
    vt[12] = '{20, 1'b0, 1'b1, 1'b0, 1'b1, 10'h0FA};
    vt[13] = '{21, 1'b0, 1'b0, 1'b1, 1'b1, 10'h0FA};
    vt[14] = '{22, 1'b1, 1'b0, 1'b0, 1'b1, 10'h0FA};

    rst_n = 1'b0; tx_valid = 1'b0; tx_d = '0; rx_realign = 1'b0; lb = 1'b1; rx_drv = 1'b0;
    rst1_n = 1'b0; tx1_valid = 1'b0; tx1_d = '0; rx1_s = 1'b1; realign1 = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_s", tx_s, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_slip", rx_slip, 0);
    chk("rst_rx_locked", rx_locked, 0);
    chk("rst_rx_d", rx_d, 0);
    rst_n = 1'b1;
    cyc = 0;

    // idle loopback, table driven
    for (int e = 1; e <= 22; e++) begin
      tick();
      foreach (vt[i]) begin
        if (vt[i].e == e) begin
          chk($sformatf("idle_tx_s_e%0d", e), tx_s, vt[i].ts);
          chk($sformatf("idle_tx_ready_e%0d", e), tx_ready, vt[i].rdy);
          chk($sformatf("idle_rx_valid_e%0d", e), rx_valid, vt[i].v);
          chk($sformatf("idle_rx_locked_e%0d", e), rx_locked, vt[i].lk);
          chk($sformatf("idle_rx_d_e%0d", e), rx_d, vt[i].d);
        end
      end
    end

    // two data words back-to-back with TX_VALID held
    slips = 0;
    tx_d = 10'h155; tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    chk("data_ready1", tx_ready, 1);
    acc1 = cyc + 1;
    tick();
    chk("data_ready_drop", tx_ready, 0);
    tx_d = 10'h2AA;
    n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    chk("data_ready2", tx_ready, 1);
    acc2 = cyc + 1;
    tick();
    tx_valid = 1'b0; tx_d = '0;
    chk("accept_edge1", acc1, 31);
    chk("accept_spacing", acc2 - acc1, 10);
    run_to(acc1 + 10);
    chk("word1_valid", rx_valid, 1);
    chk("word1_d", rx_d, 10'h155);
    run_to(acc1 + 11);
    chk("word1_valid_drop", rx_valid, 0);
    chk("word1_d_hold", rx_d, 10'h155);
    run_to(acc1 + 20);
    chk("word2_valid", rx_valid, 1);
    chk("word2_d", rx_d, 10'h2AA);
    run_to(acc1 + 30);
    chk("idle_after_data_valid", rx_valid, 1);
    chk("idle_after_data_d", rx_d, 10'h0FA);
    chk("data_no_slip", slips, 0);

    // three extra zeros before the next comma (stream driven by the bench)
    lb = 1'b0;
    slips = 0;
    for (j = 1; j <= 33; j++) begin
      rx_drv = (j <= 3) ? 1'b0 : idle_w[(j - 4) % 10];
      tick();
      if (rx_slip) slips++;
      if (j == 10) begin
        chk("slip_old_boundary_valid", rx_valid, 1);
        chk("slip_old_boundary_noslip", rx_slip, 0);
        chk("slip_old_boundary_d", rx_d, 10'h3D0);
      end
      if (j == 13) begin
        chk("slip_valid", rx_valid, 1);
        chk("slip_pulse", rx_slip, 1);
        chk("slip_d", rx_d, 10'h0FA);
        chk("slip_locked", rx_locked, 1);
      end
      if (j == 14) begin
        chk("slip_valid_drop", rx_valid, 0);
        chk("slip_pulse_drop", rx_slip, 0);
        chk("slip_d_hold", rx_d, 10'h0FA);
      end
      if (j == 23) begin
        chk("new_boundary_valid", rx_valid, 1);
        chk("new_boundary_noslip", rx_slip, 0);
        chk("new_boundary_d", rx_d, 10'h0FA);
      end
    end
    chk("slip_count", slips, 1);

    // forced realign on a comma-completing edge, then relock on the next comma
    for (j = 34; j <= 53; j++) begin
      rx_drv = idle_w[(j - 4) % 10];
      rx_realign = (j == 43);
      tick();
      rx_realign = 1'b0;
      if (j == 43) begin
        chk("realign_locked", rx_locked, 0);
        chk("realign_valid", rx_valid, 0);
        chk("realign_slip", rx_slip, 0);
      end
      if (j == 52) begin
        chk("hunt_locked", rx_locked, 0);
        chk("hunt_valid", rx_valid, 0);
      end
      if (j == 53) begin
        chk("relock_locked", rx_locked, 1);
        chk("relock_valid", rx_valid, 1);
        chk("relock_d", rx_d, 10'h0FA);
        chk("relock_slip", rx_slip, 0);
      end
    end

    // one-cycle reset with TX mid-word (tc=4, TX_S showing bit 4 = 1)
    lb = 1'b1;
    n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    chk("pre_rst_ready", tx_ready, 1);
    repeat (5) tick();
    chk("pre_rst_tx_s", tx_s, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_s", tx_s, 0);
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_locked", rx_locked, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_rx_d", rx_d, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0; vcnt = 0; lcnt = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (rx_valid) vcnt++;
      if (rx_locked) lcnt++;
    end
    chk("post_rst_no_valid", vcnt, 0);
    chk("post_rst_no_lock", lcnt, 0);
    tick();
    chk("post_rst_relock", rx_locked, 1);
    chk("post_rst_valid", rx_valid, 1);
    chk("post_rst_d", rx_d, 10'h0FA);

    // alignment disabled: RX_S held high, realign request must be ignored
    chk("free_rst_locked", rx1_locked, 1);
    chk("free_rst_valid", rx1_valid, 0);
    rst1_n = 1'b1;
    vcnt = 0; slips = 0;
    for (int e = 1; e <= 20; e++) begin
      realign1 = (e == 15);
      tick();
      realign1 = 1'b0;
      if (rx1_valid) vcnt++;
      if (rx1_slip) slips++;
      if (e == 10 || e == 20) begin
        chk($sformatf("free_valid_e%0d", e), rx1_valid, 1);
        chk($sformatf("free_d_e%0d", e), rx1_d, 10'h3FF);
        chk($sformatf("free_locked_e%0d", e), rx1_locked, 1);
      end
    end
    chk("free_valid_count", vcnt, 2);
    chk("free_no_slip", slips, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
